// File: rtl/mux_rr_pipe_pkg.sv
// Shared definitions for the stream-mux family: mode encoding and index-width helper.
package mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  // Number of bits needed to index n channels (never less than one).
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_rr_pipe_pick.sv
// Combinational rotating-priority picker: lowest requesting index at or after base,
// wrapping to the bottom of the request vector.
module rr_pick
  import mux_pkg::*;
#(
  parameter  int unsigned NCH  = 8,
  localparam int unsigned SELW = idx_bits(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] base,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [2*NCH-1:0] req2;
  logic [2*NCH-1:0] masked;

  always_comb begin
    req2 = {req, req};
    // Upper copy covers the wrap, so a single lowest-bit search over the masked
    // double vector yields the rotated priority winner.
    for (int unsigned i = 0; i < 2 * NCH; i++) begin
      masked[i] = req2[i] && (i >= 32'(base));
    end
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int unsigned i = 2 * NCH; i > 0; i--) begin
      if (masked[i-1]) begin
        gnt_vld = 1'b1;
        gnt_idx = SELW'((i - 1) % NCH);
      end
    end
  end

endmodule

// File: rtl/mux_rr_pipe.sv
// N-channel stream mux with registered output, direct or round-robin selection,
// and valid/ready handshaking on every input and on the output.
module mux_rr_pipe
  import mux_pkg::*;
#(
  parameter  int unsigned NCH  = 8,
  parameter  int unsigned W    = 8,
  localparam int unsigned SELW = idx_bits(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [NCH*W-1:0]   in_data,
  input  logic [NCH-1:0]     in_valid,
  output logic [NCH-1:0]     in_ready,
  output logic [W-1:0]       out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic            is_rr;
  logic            live;
  logic            load;
  logic            fire;
  logic            dir_vld;
  logic            rr_vld;
  logic            gnt_vld;
  logic [SELW-1:0] rr_idx;
  logic [SELW-1:0] gnt_idx;
  logic [SELW-1:0] rr_ptr;
  logic [W-1:0]    gnt_data;

  assign is_rr = (mode_e'(mode) == MODE_RR);

  rr_pick #(.NCH(NCH)) u_pick (
    .req    (in_valid),
    .base   (rr_ptr),
    .gnt_idx(rr_idx),
    .gnt_vld(rr_vld)
  );

  always_comb begin
    // An out-of-range sel matches no channel and so never grants.
    dir_vld = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (32'(sel) == i) dir_vld = in_valid[i];
    end
    gnt_vld  = is_rr ? rr_vld : dir_vld;
    gnt_idx  = is_rr ? rr_idx : sel;
    load     = !out_valid || out_ready;
    fire     = live && load && gnt_vld;
    in_ready = '0;
    gnt_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (32'(gnt_idx) == i) begin
        in_ready[i] = fire;
        gnt_data    = in_data[i*W +: W];
      end
    end
  end

  // live holds producers off until the first edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else begin
      live <= 1'b1;
      if (load) begin
        out_valid <= fire;
        if (fire) begin
          out_data <= gnt_data;
          out_chan <= gnt_idx;
          if (is_rr) rr_ptr <= (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

endmodule
